pll_cfg_seq: RTL and testbench

PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

---
 rtl/pll_cfg_seq.sv | 143 ++++++++++++++
 tb/tb_pll_cfg_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: streams config entries onto the reconfig bus,
// starts the PLL, polls status, then waits for lock under a bounded timeout.
module pll_cfg_seq #(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int POLL_GAP     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [5:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        cfg_last,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        pll_hold
);

  localparam int CW = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [CW-1:0] TO_MAX   = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST  = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_DATA_WAIT, S_DATA_WR, S_START,
    S_POLL_GAP, S_POLL_RD, S_LOCK_WAIT, S_FINISH
  } state_t;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [5:0]  addr;
    logic [31:0] data;
  } mgmt_req_t;

  state_t      state, nxt;
  mgmt_req_t   req;
  logic        lock_meta, lock_sync;
  logic [CW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic [5:0]  lat_addr;
  logic [31:0] lat_data;
  logic        lat_last;
  logic        error_q;
  logic        run, to_hit, set_err;
  logic        unused_rd;

  assign unused_rd = ^mgmt_readdata[31:1];

  // Timeout window covers polling and lock wait; the start write resets it.
  assign run    = (state == S_POLL_GAP) || (state == S_POLL_RD) || (state == S_LOCK_WAIT);
  assign to_hit = run && (to_cnt >= TO_LAST);

  always_comb begin
    nxt       = state;
    req       = '0;
    cfg_ready = 1'b0;
    case (state)
      S_IDLE:      if (cfg_valid) nxt = S_MODE;
      S_MODE: begin
        req = '{wr: 1'b1, rd: 1'b0, addr: 6'd0, data: 32'h0000_0001};
        if (!mgmt_waitrequest) nxt = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        cfg_ready = 1'b1;
        if (cfg_valid) nxt = S_DATA_WR;
      end
      S_DATA_WR: begin
        req = '{wr: 1'b1, rd: 1'b0, addr: lat_addr, data: lat_data};
        if (!mgmt_waitrequest) nxt = lat_last ? S_START : S_DATA_WAIT;
      end
      S_START: begin
        req = '{wr: 1'b1, rd: 1'b0, addr: 6'd2, data: 32'h0};
        if (!mgmt_waitrequest) nxt = S_POLL_GAP;
      end
      S_POLL_GAP: begin
        if (to_hit)                   nxt = S_FINISH;
        else if (gap_cnt >= GAP_LAST) nxt = S_POLL_RD;
      end
      S_POLL_RD: begin
        // A stalled read must complete before the timeout can take effect.
        req = '{wr: 1'b0, rd: 1'b1, addr: 6'd1, data: 32'h0};
        if (!mgmt_waitrequest) begin
          if (to_hit)                nxt = S_FINISH;
          else if (mgmt_readdata[0]) nxt = S_LOCK_WAIT;
          else                       nxt = S_POLL_GAP;
        end
      end
      S_LOCK_WAIT: if (to_hit || lock_sync) nxt = S_FINISH;
      S_FINISH:    nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  assign set_err = to_hit && (nxt == S_FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_last  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= nxt;
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
      gap_cnt   <= (state == S_POLL_GAP && nxt == S_POLL_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == S_START && nxt == S_POLL_GAP) to_cnt <= '0;
      else if (run && to_cnt < TO_MAX)           to_cnt <= to_cnt + CW'(1);
      if (state == S_DATA_WAIT && cfg_valid) begin
        lat_addr <= cfg_addr;
        lat_data <= cfg_data;
        lat_last <= cfg_last;
      end
      if (state == S_IDLE && cfg_valid) error_q <= 1'b0;
      else if (set_err)                 error_q <= 1'b1;
    end
  end

  assign mgmt_write     = req.wr;
  assign mgmt_read      = req.rd;
  assign mgmt_address   = req.addr;
  assign mgmt_writedata = req.data;
  assign busy           = (state != S_IDLE);
  assign pll_hold       = (state != S_IDLE);
  assign done           = (state == S_FINISH) && !error_q;
  assign error          = error_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq: bus responder with stalls/status script, transaction
// log checked against an expected transfer list built from the sequence rules.
module tb_pll_cfg_seq;
  localparam int LT = 100;
  localparam int PG = 4;

  logic        clk = 0, rst = 1;
  logic        cfg_valid = 0, cfg_last = 0;
  logic [5:0]  cfg_addr = 0;
  logic [31:0] cfg_data = 0;
  logic        cfg_ready;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = 0;
  logic        mgmt_waitrequest = 0;
  logic        pll_locked = 0;
  logic        busy, done, error, pll_hold;

  always #5 clk = ~clk;

  pll_cfg_seq #(.LOCK_TIMEOUT(LT), .POLL_GAP(PG)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
    .busy(busy), .done(done), .error(error), .pll_hold(pll_hold)
  );

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  int   tests = 0, fails = 0;
  int   cyc = 0;
  logic rst_edge = 1;
  txn_t log_q[$];
  bit   stat_q[$];
  bit   stat_default = 1, pop_pend = 0, hold_chk = 0;
  logic [39:0] held = 0;
  int   stall_cfg = 0, stall_left = 0;
  int   start_cyc = 0, lock_delay = 0, done_cnt = 0, err_cyc = 0;
  bit   start_seen = 0, lock_en = 0, err_seen = 0;
  logic [5:0]  ea[8];
  logic [31:0] ed[8];
  int   en = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  // Responder: stalls each transfer stall_cfg cycles, logs accepts, scripts status.
  always @(negedge clk) begin
    txn_t t;
    if (pop_pend) begin
      if (stat_q.size() > 0) void'(stat_q.pop_front());
      pop_pend = 0;
    end
    if (hold_chk && !rst_edge)
      chk("stall_stable", {24'b0, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, {24'b0, held});
    hold_chk = 0;
    chk("strobe_excl", {63'b0, mgmt_write & mgmt_read}, 64'b0);
    mgmt_readdata = {31'b0, (stat_q.size() > 0) ? stat_q[0] : stat_default};
    if (mgmt_write || mgmt_read) begin
      if (stall_left > 0) begin
        mgmt_waitrequest = 1;
        stall_left--;
        hold_chk = 1;
        held = {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
      end else begin
        mgmt_waitrequest = 0;
        if (!rst) begin
          t.wr = mgmt_write; t.addr = mgmt_address;
          t.data = mgmt_write ? mgmt_writedata : 32'h0; t.cyc = cyc + 1;
          log_q.push_back(t);
          stall_left = stall_cfg;
          if (mgmt_read) pop_pend = 1;
          if (mgmt_write && mgmt_address == 6'd2) begin start_seen = 1; start_cyc = cyc + 1; end
        end
      end
    end else mgmt_waitrequest = 0;
    if (!rst && done) done_cnt++;
    if (error && !err_seen) begin err_seen = 1; err_cyc = cyc; end
    pll_locked = lock_en && start_seen && (cyc >= start_cyc + lock_delay);
  end

  task automatic rand_entries();
    en = $urandom_range(1, 4);
    for (int k = 0; k < en; k++) begin
      ea[k] = 6'($urandom_range(3, 63));
      ed[k] = $urandom;
    end
  endtask

  task automatic run_seq(input int zeros, input int stall, input int ldly, input bit ok, input string nm);
    int   i = 0, g = 0, prev;
    bit   rdy;
    txn_t e;
    txn_t exp_q[$];
    log_q.delete(); stat_q.delete();
    for (int k = 0; k < zeros; k++) stat_q.push_back(1'b0);
    if (ok) stat_q.push_back(1'b1);
    stat_default = ok; stall_cfg = stall; stall_left = stall; pop_pend = 0;
    start_seen = 0; lock_en = ok; lock_delay = ldly; done_cnt = 0; err_seen = 0;
    cfg_valid = 1;
    while (i < en && g < 3000) begin
      cfg_addr = ea[i]; cfg_data = ed[i]; cfg_last = (i == en - 1);
      rdy = cfg_ready;
      @(posedge clk); #1;
      if (g == 0) chk({nm, "_start"}, {61'b0, busy, pll_hold, error}, 64'b110);
      if (rdy) i++;
      g++;
    end
    cfg_valid = 0;
    while (busy && g < 3000) begin @(posedge clk); #1; g++; end
    chk({nm, "_complete"}, {63'b0, g < 3000}, 64'd1);
    // Expected transfers: mode write, each entry, start write, then status reads.
    e.wr = 1; e.addr = 0; e.data = 1; exp_q.push_back(e);
    for (int k = 0; k < en; k++) begin e.addr = ea[k]; e.data = ed[k]; exp_q.push_back(e); end
    e.addr = 2; e.data = 0; exp_q.push_back(e);
    if (ok) begin
      e.wr = 0; e.addr = 1; e.data = 0;
      for (int k = 0; k <= zeros; k++) exp_q.push_back(e);
      chk({nm, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < log_q.size())
        chk($sformatf("%s_txn%0d", nm, k), {25'b0, log_q[k].wr, log_q[k].addr, log_q[k].data},
            {25'b0, exp_q[k].wr, exp_q[k].addr, exp_q[k].data});
      else chk($sformatf("%s_missing%0d", nm, k), 64'd0, 64'd1);
    end
    chk({nm, "_busy"}, {62'b0, busy, pll_hold}, 64'b0);
    if (ok) begin
      chk({nm, "_done"}, 64'(done_cnt), 64'd1);
      chk({nm, "_error"}, {63'b0, error}, 64'd0);
      prev = start_cyc;
      foreach (log_q[k]) if (!log_q[k].wr) begin
        chk($sformatf("%s_gap%0d", nm, k), {63'b0, (log_q[k].cyc - prev) >= PG + 1}, 64'd1);
        prev = log_q[k].cyc;
      end
    end else begin
      chk({nm, "_nodone"}, 64'(done_cnt), 64'd0);
      chk({nm, "_error"}, {63'b0, error}, 64'd1);
      chk({nm, "_err_time"}, 64'(err_cyc - start_cyc), 64'(LT));
      repeat (10) @(posedge clk);
      #1;
      chk({nm, "_err_sticky"}, {63'b0, error}, 64'd1);
    end
  endtask

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {57'b0, mgmt_write, mgmt_read, cfg_ready, busy, done, error, pll_hold}, 64'b0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outputs", {57'b0, mgmt_write, mgmt_read, cfg_ready, busy, done, error, pll_hold}, 64'b0);

    en = 3;
    ea[0] = 6'h04; ed[0] = 32'h0000_0505;
    ea[1] = 6'h03; ed[1] = 32'h0001_0101;
    ea[2] = 6'h05; ed[2] = 32'h0000_0202;
    run_seq(0, 0, 0, 1, "basic");
    run_seq(0, 5, 0, 1, "stall5");
    run_seq(3, 0, 2, 1, "poll3");
    for (int r = 0; r < 6; r++) begin
      rand_entries();
      run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15), 1,
              $sformatf("rnd%0d", r));
    end

    rand_entries();
    run_seq(0, 0, 0, 0, "timeout");
    rand_entries();
    run_seq(1, 1, 3, 1, "after_to");

    // Reset while an entry write is stalled on the bus.
    en = 3;
    ea[0] = 6'h04; ed[0] = 32'h0000_0505;
    log_q.delete(); stat_q.delete(); stat_default = 1;
    stall_cfg = 50; stall_left = 50; lock_en = 1; lock_delay = 0; start_seen = 0;
    cfg_valid = 1; cfg_addr = ea[0]; cfg_data = ed[0]; cfg_last = 0;
    g = 0;
    while (!(mgmt_write && mgmt_address == 6'h04) && g < 500) begin @(posedge clk); #1; g++; end
    chk("rst_reach_dwr", {63'b0, g < 500}, 64'd1);
    rst = 1; cfg_valid = 0;
    @(posedge clk); #1;
    chk("rst_midxfer", {57'b0, mgmt_write, mgmt_read, cfg_ready, busy, done, error, pll_hold}, 64'b0);
    rst = 0;
    stall_cfg = 0; stall_left = 0;
    @(posedge clk); #1;
    ea[1] = 6'h03; ed[1] = 32'h0001_0101;
    ea[2] = 6'h05; ed[2] = 32'h0000_0202;
    run_seq(0, 0, 0, 1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
